// File: rtl/fifo_rr_arbiter.sv
// Frame-aware round-robin arbiter draining NUM_PORTS first-word-fall-through FIFOs into one stream.
// Define FIFO_ARB_WATCHDOG_EN to compile in the starvation watchdog that abandons a stalled grant.
module fifo_rr_arbiter #(
   parameter int  NUM_PORTS      = 4,
   parameter int  DATA_WIDTH     = 9,
   parameter int  TIMEOUT_CYCLES = 256,
   localparam int PW             = ($clog2(NUM_PORTS) > 0) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   output logic [NUM_PORTS-1:0]            r_en,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] r_data,
   input  logic [NUM_PORTS-1:0]            r_empty,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_WIDTH-2:0]           out_data,
   output logic                            out_last,
   output logic [PW-1:0]                   out_port,
   output logic                            busy,
   output logic                            timeout_err
);

   if (NUM_PORTS < 2) begin : g_bad_ports
      $error("fifo_rr_arbiter: NUM_PORTS must be at least 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("fifo_rr_arbiter: TIMEOUT_CYCLES must be positive");
   end

   typedef enum logic {IDLE, XFER} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         grant_q, grant_d;
   logic [PW-1:0]         last_q, last_d;
   logic [PW-1:0]         rr_sel, rr_idx;
   logic                  found;
   logic [DATA_WIDTH-1:0] gnt_word;
   logic                  gnt_empty;
   logic                  xfer;
   logic                  hs;
   logic                  tmo;

   assign xfer      = (state_q == XFER);
   assign gnt_empty = r_empty[grant_q];
   assign out_valid = xfer & ~gnt_empty;
   assign hs        = out_valid & out_ready;
   assign busy      = xfer;

   always_comb begin
      gnt_word = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_q == PW'(i)) gnt_word = r_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Egress fields are zeroed outside a grant so idle cycles present a clean bus.
   assign out_data = xfer ? gnt_word[DATA_WIDTH-2:0] : '0;
   assign out_last = xfer & gnt_word[DATA_WIDTH-1];
   assign out_port = xfer ? grant_q : '0;

   always_comb begin
      r_en          = '0;
      r_en[grant_q] = hs;
   end

   always_comb begin
      rr_sel = last_q;
      rr_idx = '0;
      found  = 1'b0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         rr_idx = PW'((int'(last_q) + k) % NUM_PORTS);
         if (!found && !r_empty[rr_idx]) begin
            rr_sel = rr_idx;
            found  = 1'b1;
         end
      end
   end

`ifdef FIFO_ARB_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] stall_q, stall_d;

   // Only starvation counts: backpressure cycles hold the count, handshakes clear it.
   always_comb begin
      stall_d = '0;
      tmo     = 1'b0;
      if (xfer && !hs) begin
         stall_d = stall_q;
         if (gnt_empty) begin
            if (stall_q == CW'(TIMEOUT_CYCLES - 1)) begin
               tmo     = 1'b1;
               stall_d = '0;
            end else begin
               stall_d = stall_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
   end
`else
   assign tmo = 1'b0;
`endif

   assign timeout_err = tmo;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = rr_sel;
               state_d = XFER;
            end
         end
         XFER: begin
            if (tmo || (hs && out_last)) begin
               last_d  = grant_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= PW'(NUM_PORTS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: FWFT FIFO models on each port and a queue scoreboard on the egress.
module tb_fifo_rr_arbiter;
   localparam int NP    = 4;
   localparam int DW    = 9;
   localparam int DEPTH = 64;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NP-1:0]     r_en;
   logic [NP*DW-1:0]  r_data;
   logic [NP-1:0]     r_empty;
   logic              out_valid;
   logic              out_ready;
   logic [DW-2:0]     out_data;
   logic              out_last;
   logic [1:0]        out_port;
   logic              busy;
   logic              timeout_err;

   typedef struct packed {
      logic [1:0]    port;
      logic [DW-1:0] word;
   } exp_t;

   typedef struct {
      int         last;
      logic [3:0] mask;
      int         expp;
   } vec_t;

   exp_t          expq[$];
   exp_t          e;
   logic [DW-1:0] mem [NP][DEPTH];
   int            wr_ptr [NP] = '{default: 0};
   int            rd_ptr [NP] = '{default: 0};
   int            total = 0;
   int            bad   = 0;

   always #5 clk = ~clk;

   fifo_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(256)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .r_en        (r_en),
      .r_data      (r_data),
      .r_empty     (r_empty),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .out_port    (out_port),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always_comb begin
      r_empty = '0;
      r_data  = '0;
      for (int i = 0; i < NP; i++) begin
         r_empty[i]         = (rd_ptr[i] == wr_ptr[i]);
         r_data[i*DW +: DW] = mem[i][rd_ptr[i] % DEPTH];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < NP; i++) begin
         if (r_en[i]) rd_ptr[i] <= rd_ptr[i] + 1;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
      end
   endtask

   task automatic fifo_push(input int p, input logic [DW-1:0] w);
      mem[p][wr_ptr[p] % DEPTH] = w;
      wr_ptr[p]++;
   endtask

   task automatic exp_push(input int p, input logic [DW-1:0] w);
      exp_t x;
      x.port = 2'(p);
      x.word = w;
      expq.push_back(x);
   endtask

   task automatic both(input int p, input logic [DW-1:0] w);
      fifo_push(p, w);
      exp_push(p, w);
   endtask

   task automatic wait_hs(input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(out_valid && out_ready) && n < 50);
      if (!(out_valid && out_ready)) begin
         total++;
         bad++;
         $display("FAIL %s: no handshake within 50 cycles", nm);
      end
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while ((busy || expq.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (busy || expq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s: still busy=%0d with %0d words owed after 400 cycles", nm, busy, expq.size());
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check("r_en", 32'(r_en), (out_valid && out_ready) ? (32'd1 << out_port) : 32'd0);
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_extra: got port %0d word 0x%0h, required no word", out_port, {out_last, out_data});
            end else begin
               e = expq.pop_front();
               check("sb_port", 32'(out_port), 32'(e.port));
               check("sb_word", 32'({out_last, out_data}), 32'(e.word));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench still running, required completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      vec_t        vecs [6];
      logic [11:0] vpat;
      logic [4:0]  vp;
      bit          ok;
      int          p;

      vecs[0] = '{3, 4'b0011, 0};
      vecs[1] = '{0, 4'b1111, 1};
      vecs[2] = '{1, 4'b0001, 0};
      vecs[3] = '{2, 4'b0110, 1};
      vecs[4] = '{1, 4'b1101, 2};
      vecs[5] = '{0, 4'b1001, 3};

      // Reset with every port preloaded with a 2-word frame.
      rst_n     = 1'b0;
      out_ready = 1'b1;
      for (int q = 0; q < NP; q++) begin
         both(q, {1'b0, 8'(q*16)});
         both(q, {1'b1, 8'(q*16 + 1)});
      end
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_ren", 32'(r_en), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_fields", 32'({out_last, out_data, out_port}), 0);
      check("rst_tmo", 32'(timeout_err), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("pre_idle", 32'(out_valid), 0);
      vpat = '0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         vpat = {vpat[10:0], out_valid};
      end
      check("pre_valid_pattern", 32'(vpat), 32'(12'b110110110110));
      wait_idle("pre_drain");

      // Single 4-word frame on port 1.
      @(posedge clk); #1;
      both(1, 9'h010); both(1, 9'h011); both(1, 9'h012); both(1, 9'h113);
      @(negedge clk);
      check("p1_latency", 32'(out_valid), 0);
      vp = '0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         vp = {vp[3:0], out_valid};
         if (k == 0) check("p1_port", 32'(out_port), 1);
      end
      check("p1_valid_run", 32'(vp), 32'(5'b11110));
      check("p1_busy_drop", 32'(busy), 0);
      wait_idle("p1_drain");

      // Round-robin table: a single-word frame on 'last' sets priority, then 'mask' contends.
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         both(vecs[i].last, {1'b1, 8'(8'hA0 + i)});
         wait_hs("tbl_setup");
         @(posedge clk); #1;
         for (int k = 0; k < NP; k++) begin
            p = (vecs[i].expp + k) % NP;
            if (vecs[i].mask[p]) both(p, {1'b1, 8'(i*16 + p)});
         end
         @(negedge clk);
         check("tbl_bubble", 32'(out_valid), 0);
         @(negedge clk);
         check("tbl_grant", 32'(out_port), 32'(vecs[i].expp));
         check("tbl_valid", 32'(out_valid), 1);
         wait_idle("tbl_drain");
      end

      // Backpressure 1,0,0,1 mid-frame on port 2.
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) both(2, 9'(32 + k));
      both(2, 9'h124);
      wait_hs("bp_first");
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("bp_data1", 32'({out_last, out_data}), 32'h021);
      check("bp_valid1", 32'(out_valid), 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_data2", 32'({out_last, out_data}), 32'h021);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_idle("bp_drain");

      // Port 1 starves after word 2 of 5 for 300 cycles while port 2 waits.
      @(posedge clk); #1;
      both(1, 9'h030); both(1, 9'h031);
      wait_hs("st_w0");
      wait_hs("st_w1");
      @(posedge clk); #1;
      fifo_push(2, 9'h040); fifo_push(2, 9'h141);
`ifdef FIFO_ARB_WATCHDOG_EN
      exp_push(2, 9'h040); exp_push(2, 9'h141);
      exp_push(1, 9'h032); exp_push(1, 9'h033); exp_push(1, 9'h134);
`else
      exp_push(1, 9'h032); exp_push(1, 9'h033); exp_push(1, 9'h134);
      exp_push(2, 9'h040); exp_push(2, 9'h141);
`endif
      ok = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
`ifdef FIFO_ARB_WATCHDOG_EN
         if (timeout_err !== (k == 256)) ok = 1'b0;
         if (k <= 257 && busy !== (k <= 256)) ok = 1'b0;
`else
         if (timeout_err || !busy || out_valid || out_port != 2'd1) ok = 1'b0;
`endif
      end
      check("stall_behaviour", 32'(ok), 1);
      @(posedge clk); #1;
      fifo_push(1, 9'h032); fifo_push(1, 9'h033); fifo_push(1, 9'h134);
      wait_idle("stall_drain");

      // Asynchronous reset in the middle of a port 0 frame.
      @(posedge clk); #1;
      both(0, 9'h050); both(0, 9'h051); both(0, 9'h052); both(0, 9'h153);
      wait_hs("ar_w0");
      wait_hs("ar_w1");
      @(posedge clk); #1;
      both(1, 9'h060); both(1, 9'h161);
      rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(out_valid), 0);
      check("ar_busy", 32'(busy), 0);
      check("ar_ren", 32'(r_en), 0);
      check("ar_fields", 32'({out_last, out_data, out_port}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("ar_idle", 32'(out_valid), 0);
      @(negedge clk);
      check("ar_prio_port", 32'(out_port), 0);
      check("ar_prio_valid", 32'(out_valid), 1);
      wait_idle("ar_drain");

      check("sb_left", 32'(expq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
